// File: rtl/bcd_countdown_timer.sv
// ---------------------------------------------------------------------------
// bcd_countdown_timer
// MM:SS countdown timer held as four BCD digits (00:00 .. 59:59).
// States: IDLE (00), RUN (01), PAUSE (10), DONE (11).
// A one-cycle 'en' strobe (1 Hz tick) decrements the count while running.
// The input priority within one cycle is load_en > stop > start > en.
// A higher input only masks the lower ones when it actually acts: load_en
// is ignored in RUN, and the remaining inputs are then evaluated as usual.
// All outputs are registered. The reset is synchronous and active-low.
// ---------------------------------------------------------------------------
module bcd_countdown_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       start,
    input  logic       stop,
    input  logic       load_en,
    input  logic [3:0] load_min_t,
    input  logic [3:0] load_min_o,
    input  logic [3:0] load_sec_t,
    input  logic [3:0] load_sec_o,
    output logic [3:0] min_t,
    output logic [3:0] min_o,
    output logic [3:0] sec_t,
    output logic [3:0] sec_o,
    output logic [1:0] state,
    output logic       running,
    output logic       done,
    output logic       expired
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_PAUSE = 2'b10;
    localparam logic [1:0] ST_DONE  = 2'b11;

    // Tens digits of minutes and seconds saturate at 5.
    function automatic logic [3:0] clamp_tens(input logic [3:0] d);
        logic [3:0] r;
        if (d > 4'd5) begin
            r = 4'd5;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Ones digits saturate at 9. This keeps every digit a valid BCD value.
    function automatic logic [3:0] clamp_ones(input logic [3:0] d);
        logic [3:0] r;
        if (d > 4'd9) begin
            r = 4'd9;
        end else begin
            r = d;
        end
        return r;
    endfunction

    // Subtract one second from the packed count {min_t, min_o, sec_t, sec_o}.
    // The result saturates at 00:00 and never underflows.
    function automatic logic [15:0] bcd_dec(input logic [15:0] c);
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
        mt = c[15:12];
        mo = c[11:8];
        st = c[7:4];
        so = c[3:0];
        if (c == 16'h0000) begin
            // Already at zero: hold the count.
            mt = 4'd0;
            mo = 4'd0;
            st = 4'd0;
            so = 4'd0;
        end else if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    if (mt != 4'd0) begin
                        mt = mt - 4'd1;
                    end else begin
                        mt = 4'd0;
                    end
                end
            end
        end
        return {clamp_tens(mt), clamp_ones(mo), clamp_tens(st), clamp_ones(so)};
    endfunction

    logic [15:0] count_r;
    logic [1:0]  state_r;
    logic        running_r;
    logic        done_r;
    logic        expired_r;

    logic [15:0] count_nxt_s;
    logic [1:0]  state_nxt_s;
    logic        expired_nxt_s;
    logic [15:0] load_val_s;
    logic [15:0] dec_val_s;
    logic        count_zero_s;

    assign load_val_s   = {clamp_tens(load_min_t), clamp_ones(load_min_o),
                           clamp_tens(load_sec_t), clamp_ones(load_sec_o)};
    assign dec_val_s    = bcd_dec(count_r);
    assign count_zero_s = (count_r == 16'h0000);

    // Next-state and next-count selection using the input priority.
    always_comb begin
        count_nxt_s   = count_r;
        state_nxt_s   = state_r;
        expired_nxt_s = 1'b0;
        if (load_en && (state_r != ST_RUN)) begin
            count_nxt_s = load_val_s;
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // A start with a zero count is refused: there is nothing to run.
                    if (start && !count_zero_s) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_nxt_s = ST_PAUSE;
                    end else if (en) begin
                        count_nxt_s = dec_val_s;
                        if (dec_val_s == 16'h0000) begin
                            state_nxt_s   = ST_DONE;
                            expired_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s = ST_RUN;
                        end
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (stop) begin
                        state_nxt_s = ST_IDLE;
                    end else if (start) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_PAUSE;
                    end
                end
                ST_DONE: begin
                    if (stop || start) begin
                        state_nxt_s = ST_IDLE;
                        count_nxt_s = 16'h0000;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    count_nxt_s = 16'h0000;
                end
            endcase
        end
    end

    // Registered state, count and flags. A reset overrides every other input.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r   <= 16'h0000;
            state_r   <= ST_IDLE;
            running_r <= 1'b0;
            done_r    <= 1'b0;
            expired_r <= 1'b0;
        end else begin
            count_r   <= count_nxt_s;
            state_r   <= state_nxt_s;
            running_r <= (state_nxt_s == ST_RUN);
            done_r    <= (state_nxt_s == ST_DONE);
            expired_r <= expired_nxt_s;
        end
    end

    assign min_t   = count_r[15:12];
    assign min_o   = count_r[11:8];
    assign sec_t   = count_r[7:4];
    assign sec_o   = count_r[3:0];
    assign state   = state_r;
    assign running = running_r;
    assign done    = done_r;
    assign expired = expired_r;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed testbench for bcd_countdown_timer.
module tb_bcd_countdown_timer;

    logic       clk;
    logic       rst;
    logic       en;
    logic       start;
    logic       stop;
    logic       load_en;
    logic [3:0] load_min_t;
    logic [3:0] load_min_o;
    logic [3:0] load_sec_t;
    logic [3:0] load_sec_o;
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
    logic [1:0] state;
    logic       running;
    logic       done;
    logic       expired;

    int checks = 0;
    int errors = 0;

    bcd_countdown_timer dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop),
        .load_en(load_en), .load_min_t(load_min_t), .load_min_o(load_min_o),
        .load_sec_t(load_sec_t), .load_sec_o(load_sec_o),
        .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o),
        .state(state), .running(running), .done(done), .expired(expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic r, input logic ld, input logic sp,
                       input logic st, input logic e);
        rst = r; load_en = ld; stop = sp; start = st; en = e;
        @(posedge clk);
        #1;
        rst = 1'b1; load_en = 1'b0; stop = 1'b0; start = 1'b0; en = 1'b0;
    endtask

    task automatic load(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [3:0] d);
        load_min_t = a; load_min_o = b; load_sec_t = c; load_sec_o = d;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] cnt();
        return {min_t, min_o, sec_t, sec_o};
    endfunction

    function automatic logic [15:0] flags();
        return {11'd0, state, running, done, expired};
    endfunction

    // flags encoding: {state[1:0], running, done, expired}
    initial begin
        rst = 1'b0; en = 1'b0; start = 1'b0; stop = 1'b0; load_en = 1'b0;
        load_min_t = 4'd0; load_min_o = 4'd0; load_sec_t = 4'd0; load_sec_o = 4'd0;

        // Reset state
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_count", cnt(), 16'h0000);
        chk("reset_flags", flags(), 16'h0000);

        // Load 01:00, start, one tick -> 00:59
        load(4'd0, 4'd1, 4'd0, 4'd0);
        chk("load_0100", cnt(), 16'h0100);
        chk("load_idle", flags(), 16'h0000);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("start_run", flags(), 16'h000C);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("tick_0059", cnt(), 16'h0059);
        chk("tick_running", flags(), 16'h000C);
        // stop -> PAUSE, stop -> IDLE, digits held
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("pause", flags(), 16'h0010);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("pause_to_idle", flags(), 16'h0000);
        chk("idle_held", cnt(), 16'h0059);

        // Load 00:02, run to expiry
        load(4'd0, 4'd0, 4'd0, 4'd2);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("cnt_0001", cnt(), 16'h0001);
        chk("run_no_exp", flags(), 16'h000C);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("cnt_0000", cnt(), 16'h0000);
        chk("done_expired", flags(), 16'h001B);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            chk("done_hold_cnt", cnt(), 16'h0000);
            chk("done_no_exp", flags(), 16'h001A);
        end
        // DONE + start -> IDLE, count 00:00
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("done_start_idle", flags(), 16'h0000);
        chk("done_start_cnt", cnt(), 16'h0000);

        // Clamped load 7,12,9,9 -> 59:59
        load(4'd7, 4'd12, 4'd9, 4'd9);
        chk("clamp_load", cnt(), 16'h5959);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("cnt_5958", cnt(), 16'h5958);
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("cnt_5950", cnt(), 16'h5950);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("cnt_5949", cnt(), 16'h5949);

        // RUN at 10:00: stop and en together -> PAUSE, held
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        load(4'd1, 4'd0, 4'd0, 4'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("stop_en_pause", flags(), 16'h0010);
        chk("stop_en_held", cnt(), 16'h1000);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pause_ignore_en", cnt(), 16'h1000);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("resume_run", flags(), 16'h000C);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("cnt_0959", cnt(), 16'h0959);

        // IDLE at 00:00, start refused
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        load(4'd0, 4'd0, 4'd0, 4'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("zero_start", flags(), 16'h0000);

        // load_en during RUN at 05:00 is ignored
        load(4'd0, 4'd5, 4'd0, 4'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        load_min_t = 4'd1; load_min_o = 4'd1; load_sec_t = 4'd1; load_sec_o = 4'd1;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("run_load_cnt", cnt(), 16'h0500);
        chk("run_load_state", flags(), 16'h000C);
        // ignored load_en does not block en
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("run_load_en", cnt(), 16'h0459);

        // Reset during RUN at 30:15 with en high
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        load(4'd3, 4'd0, 4'd1, 4'd5);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_run_cnt", cnt(), 16'h0000);
        chk("rst_run_flags", flags(), 16'h0000);

        // Reset during the expired pulse
        load(4'd0, 4'd0, 4'd0, 4'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("pulse_before_rst", flags(), 16'h001B);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_pulse_flags", flags(), 16'h0000);
        // Responds again on the next edge after reset
        load(4'd0, 4'd0, 4'd3, 4'd0);
        chk("post_rst_load", cnt(), 16'h0030);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
